// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // Requester identity; the same encoding names the priority holder.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/rf_writeback_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arbiter2
  import rf_writeback_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       a_valid,
  input  logic       b_valid,
  input  logic       xfer,
  output logic [1:0] grant,
  output req_id_t    prio
);

  req_id_t prio_next;

  // Priority pointer register; reset leaves A as the preferred requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= REQ_A;
    end else begin
      prio <= prio_next;
    end
  end

  // Grant from current requests; pointer flips only after a contended transfer.
  always_comb begin
    grant     = 2'b00;
    prio_next = prio;
    if (reset && !hold) begin
      if (a_valid && b_valid) begin
        grant = (prio == REQ_A) ? 2'b01 : 2'b10;
      end else begin
        grant = {b_valid, a_valid};
      end
    end
    if (xfer && a_valid && b_valid) begin
      prio_next = (prio == REQ_A) ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the register-file write port between the ALU (A) and load (B) paths.
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int size    = 32,
  parameter int DROP_R0 = 1,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_reg,
  input  logic [size-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_reg,
  input  logic [size-1:0]       b_data,
  output logic                  b_ready,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [size-1:0]       write_data,
  output logic [CNT_W-1:0]      conflict_cnt
);

  logic [1:0]            grant;
  req_id_t               prio;
  logic                  xfer;
  logic                  sel_b;
  logic [REG_ADDR_W-1:0] sel_reg;
  logic [size-1:0]       sel_data;
  logic                  drop_write;
  logic                  conflict;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .xfer    (xfer),
    .grant   (grant),
    .prio    (prio)
  );

  // Handshake, winner selection and the register-0 suppression decision.
  always_comb begin
    a_ready    = grant[0];
    b_ready    = grant[1];
    xfer       = (a_valid && grant[0]) || (b_valid && grant[1]);
    sel_b      = (a_valid && b_valid) ? (prio == REQ_B) : b_valid;
    sel_reg    = sel_b ? b_reg : a_reg;
    sel_data   = sel_b ? b_data : a_data;
    drop_write = (DROP_R0 != 0) && (sel_reg == REG_ZERO);
    conflict   = a_valid && b_valid && !hold;
  end

  // Registered write port; address/data hold when nothing transfers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else if (xfer) begin
      reg_write      <= !drop_write;
      write_register <= sel_reg;
      write_data     <= sel_data;
    end else begin
      reg_write      <= 1'b0;
    end
  end

  // Saturating count of contended, non-held cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench: default instance plus DROP_R0=0 and CNT_W=2 variants on shared inputs.
module tb_rf_writeback_arbiter;
  import rf_writeback_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        a_valid, b_valid;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [15:0] conflict_cnt;

  logic        nd_a_ready, nd_b_ready, nd_reg_write;
  logic [4:0]  nd_write_register;
  logic [31:0] nd_write_data;
  logic [15:0] nd_conflict_cnt;

  logic        st_a_ready, st_b_ready, st_reg_write;
  logic [4:0]  st_write_register;
  logic [31:0] st_write_data;
  logic [1:0]  st_conflict_cnt;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_writeback_arbiter dut (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data), .conflict_cnt(conflict_cnt)
  );

  rf_writeback_arbiter #(.DROP_R0(0)) dut_nodrop (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(nd_a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(nd_b_ready),
    .reg_write(nd_reg_write), .write_register(nd_write_register),
    .write_data(nd_write_data), .conflict_cnt(nd_conflict_cnt)
  );

  rf_writeback_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(st_a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(st_b_ready),
    .reg_write(st_reg_write), .write_register(st_write_register),
    .write_data(st_write_data), .conflict_cnt(st_conflict_cnt)
  );

  // Drive every requester input in one go.
  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic bv, input logic [4:0] br, input logic [31:0] bd,
                               input logic h);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    hold = h;
  endtask

  // One comparison: observed against a hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1, 5'd3, 32'h11, 0, 5'd0, 32'h0, 0);
    tick();
    tick();
    checkOutput("rst_a_ready", {31'b0, a_ready}, 0);
    checkOutput("rst_reg_write", {31'b0, reg_write}, 0);
    checkOutput("rst_write_register", {27'b0, write_register}, 0);
    checkOutput("rst_write_data", write_data, 0);
    checkOutput("rst_cnt", {16'b0, conflict_cnt}, 0);
    #3 reset = 1'b1;
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    tick();

    // Continuous contention from reset: A,B,A,B,A,B.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB1, 0);
      #1;
      checkOutput("cont_a_ready", {31'b0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("cont_b_ready", {31'b0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      checkOutput("cont_reg_write", {31'b0, reg_write}, 1);
      checkOutput("cont_write_register", {27'b0, write_register}, (i % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput("cont_write_data", write_data, (i % 2 == 0) ? 32'hA1 : 32'hB1);
    end
    checkOutput("cont_cnt", {16'b0, conflict_cnt}, 6);
    checkOutput("cont_sat_cnt", {30'b0, st_conflict_cnt}, 3);

    // Idle cycle: write strobe drops, address/data hold.
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    tick();
    checkOutput("idle_reg_write", {31'b0, reg_write}, 0);
    checkOutput("idle_write_register", {27'b0, write_register}, 2);
    checkOutput("idle_write_data", write_data, 32'hB1);

    // Reset in the middle of a write.
    applyStimulus(1, 5'd3, 32'h11, 0, 5'd0, 32'h0, 0);
    #1;
    checkOutput("mid_a_ready", {31'b0, a_ready}, 1);
    tick();
    checkOutput("mid_reg_write_pre", {31'b0, reg_write}, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("mid_reg_write_rst", {31'b0, reg_write}, 0);
    checkOutput("mid_cnt_rst", {16'b0, conflict_cnt}, 0);
    checkOutput("mid_a_ready_rst", {31'b0, a_ready}, 0);
    checkOutput("mid_write_register_rst", {27'b0, write_register}, 0);
    #1 reset = 1'b1;
    #1;
    checkOutput("post_a_ready", {31'b0, a_ready}, 1);
    tick();
    checkOutput("post_reg_write", {31'b0, reg_write}, 1);
    checkOutput("post_write_register", {27'b0, write_register}, 3);
    checkOutput("post_write_data", write_data, 32'h11);

    // B streaming alone, regs 4..7.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 5'd0, 32'h0, 1, 5'(4 + i), 32'hB0 + 32'(i), 0);
      #1;
      checkOutput("strm_b_ready", {31'b0, b_ready}, 1);
      checkOutput("strm_a_ready", {31'b0, a_ready}, 0);
      tick();
      checkOutput("strm_reg_write", {31'b0, reg_write}, 1);
      checkOutput("strm_write_register", {27'b0, write_register}, 4 + i);
      checkOutput("strm_write_data", write_data, 32'hB0 + 32'(i));
    end

    // Same-register collision; priority still A after single-requester traffic.
    applyStimulus(1, 5'd9, 32'hAA, 1, 5'd9, 32'hBB, 0);
    #1;
    checkOutput("coll_a_ready", {31'b0, a_ready}, 1);
    checkOutput("coll_b_ready", {31'b0, b_ready}, 0);
    tick();
    checkOutput("coll_first_reg", {27'b0, write_register}, 9);
    checkOutput("coll_first_data", write_data, 32'hAA);
    checkOutput("coll_cnt", {16'b0, conflict_cnt}, 1);
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd9, 32'hBB, 0);
    #1;
    checkOutput("coll_b_ready2", {31'b0, b_ready}, 1);
    tick();
    checkOutput("coll_second_we", {31'b0, reg_write}, 1);
    checkOutput("coll_second_reg", {27'b0, write_register}, 9);
    checkOutput("coll_second_data", write_data, 32'hBB);

    // Write to register 0: dropped by default, issued with DROP_R0=0.
    applyStimulus(1, 5'd0, 32'hFF, 0, 5'd0, 32'h0, 0);
    #1;
    checkOutput("r0_a_ready", {31'b0, a_ready}, 1);
    tick();
    checkOutput("r0_drop_we", {31'b0, reg_write}, 0);
    checkOutput("r0_drop_reg", {27'b0, write_register}, 0);
    checkOutput("r0_drop_data", write_data, 32'hFF);
    checkOutput("r0_keep_we", {31'b0, nd_reg_write}, 1);
    checkOutput("r0_keep_reg", {27'b0, nd_write_register}, 0);

    // Hold with both valid: nothing granted, counter frozen.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd1, 32'h31, 1, 5'd2, 32'h32, 1);
      #1;
      checkOutput("hold_a_ready", {31'b0, a_ready}, 0);
      checkOutput("hold_b_ready", {31'b0, b_ready}, 0);
      tick();
      checkOutput("hold_reg_write", {31'b0, reg_write}, 0);
    end
    checkOutput("hold_cnt", {16'b0, conflict_cnt}, 1);

    // Release hold: priority is B (A won the last contention), then alternate.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 5'd1, 32'h31, 1, 5'd2, 32'h32, 0);
      #1;
      checkOutput("rel_b_ready", {31'b0, b_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
      checkOutput("rel_write_register", {27'b0, write_register}, (i % 2 == 0) ? 32'd2 : 32'd1);
      if (i == 1) checkOutput("sat_cnt_mid", {30'b0, st_conflict_cnt}, 3);
    end
    checkOutput("sat_cnt_final", {30'b0, st_conflict_cnt}, 3);
    checkOutput("wide_cnt_final", {16'b0, conflict_cnt}, 6);

    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: port A (ALU result) and port B (load/memory result). Round-robin arbitration with a valid/ready handshake per requester. Drives a registered write port (reg_write, write_register, write_data) straight into the register file, and counts dropped-priority conflicts for debug.

Parameters:
size, 32, data width of write_data and requester data.
DROP_R0, 1, when 1 a granted write to register 0 is accepted but not issued (reg_write stays 0).
CNT_W, 16, width of the conflict counter (saturating).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
hold  input  1  when 1, no grants are issued (e.g. register file being initialised).
a_valid  input  1  requester A has a write pending.
a_reg  input  5  requester A destination register.
a_data  input  size  requester A write data.
a_ready  output  1  A accepted this cycle (combinational grant).
b_valid  input  1  requester B has a write pending.
b_reg  input  5  requester B destination register.
b_data  input  size  requester B write data.
b_ready  output  1  B accepted this cycle (combinational grant).
reg_write  output  1  registered write enable to the register file.
write_register  output  5  registered write address.
write_data  output  size  registered write data.
conflict_cnt  output  CNT_W  number of cycles with both requesters valid and not held; saturates at all-ones.

Behaviour:
- Reset (reset=0, async): reg_write=0, write_register=0, write_data=0, conflict_cnt=0, priority pointer prio=A. a_ready/b_ready=0 while reset is low.
- Grant logic (combinational, from current inputs and prio):
  - hold=1: a_ready=b_ready=0.
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the requester named by prio gets ready=1; the other gets 0.
  - Neither valid: both ready=0.
- A transfer occurs when valid&&ready. Requesters hold valid, reg and data stable until ready.
- Priority pointer:
  - Updates only on a transfer, and only when both requesters were valid in that cycle.
  - The granted requester becomes lowest priority (prio flips).
  - A single-requester transfer leaves prio unchanged.
- Output stage, one-cycle latency. On the clock edge after a transfer:
  - reg_write=1, write_register=granted reg, write_data=granted data.
  - Exception: DROP_R0=1 and granted reg==0 gives reg_write=0. The handshake still completes, and address/data are still captured.
  - With no transfer: reg_write=0 on that edge; write_register/write_data hold their previous values.
- At most one write issued per cycle; back-to-back transfers give reg_write=1 on consecutive cycles.
- conflict_cnt increments by 1 on each edge where a_valid&&b_valid&&!hold. It does not wrap: it holds at 2^CNT_W-1.
- Same destination register from both requesters: no merging. The writes are serialised in grant order, so the later-granted value is the final register contents.
- Reset mid-operation: any captured-but-not-issued write is discarded; reg_write falls immediately with reset.
- hold asserted while both requesters are valid: no transfer, prio unchanged, conflict_cnt unchanged.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5.
  - Requester-ID encoding (REQ_A=0, REQ_B=1), also used as the prio encoding.
  - Register-0 address constant.
- One natural sub-module: rr_arbiter2. It takes the two valids, hold and the transfer strobe, and returns the grant vector and prio state.
- Output register and counter stay in the top module.

Test Plan:
- Reset: drive reset=0 mid-simulation with A valid → reg_write=0 and conflict_cnt=0 immediately; after release, the first A request (reg 3, data 0x11) → a_ready=1, and reg_write=1 with write_register=3, write_data=0x11 one cycle later.
- Single requester streaming: B valid for 4 cycles (regs 4..7, data 0xB0..0xB3) → b_ready=1 every cycle, reg_write=1 for 4 consecutive cycles with matching address/data, prio unchanged.
- Contention fairness: A and B both valid continuously for 6 cycles from reset → grants A,B,A,B,A,B; conflict_cnt=6.
- Same-register collision: both target reg 9 (A data 0xAA, B data 0xBB), prio=A → writes issued 0xAA then 0xBB on consecutive cycles.
- R0 drop: A writes reg 0 with data 0xFF, DROP_R0=1 → a_ready=1 and reg_write stays 0; repeated with DROP_R0=0 → reg_write=1, write_register=0.
- Hold and saturation:
  - hold=1 with both valid → no ready and no reg_write for the whole hold period.
  - With CNT_W=2, 5 contention cycles → conflict_cnt=3.
